rv_instr_encoder: RTL and testbench

- Inverse of the core's instruction decoder: accepts decoded RV32I fields (op class, registers, funct bits, full 32-bit immediate) and packs them into a 32-bit instruction word.
- Each encoded word is tagged with a sequential word address and buffered in a small FIFO.
- Used by the boot/test program loader to write instruction memory, and by the verification bench to produce decoder stimulus.

---
 rtl/rv_enc_pkg.sv | 72 +++++++
 rtl/rv_enc_fifo.sv | 47 ++++
 rtl/rv_instr_encoder.sv | 115 +++++++++++
 tb/tb_rv_instr_encoder.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_enc_pkg.sv
// Shared RV32I encoder definitions: op classes, major opcodes and format packers.
package rv_enc_pkg;

  typedef enum logic [3:0] {
    OP_LUI    = 4'd0,
    OP_AUIPC  = 4'd1,
    OP_JAL    = 4'd2,
    OP_JALR   = 4'd3,
    OP_BRANCH = 4'd4,
    OP_LOAD   = 4'd5,
    OP_STORE  = 4'd6,
    OP_OPIMM  = 4'd7,
    OP_OP     = 4'd8,
    OP_FENCE  = 4'd9,
    OP_SYSTEM = 4'd10
  } enc_op_t;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  function automatic logic [31:0] fmt_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [6:0] opc);
    return {f7, rs2, rs1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] fmt_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] opc);
    return {imm, rs1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] fmt_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [6:0] opc);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], opc};
  endfunction

  // imm holds byte-offset bits [12:1]; bit 0 is implicit.
  function automatic logic [31:0] fmt_b(input logic [12:1] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [6:0] opc);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], opc};
  endfunction

  function automatic logic [31:0] fmt_u(input logic [31:12] imm, input logic [4:0] rd,
                                        input logic [6:0] opc);
    return {imm, rd, opc};
  endfunction

  function automatic logic [31:0] fmt_j(input logic [20:1] imm, input logic [4:0] rd,
                                        input logic [6:0] opc);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, opc};
  endfunction

  // True when v is representable as a two's-complement value of the given width.
  function automatic logic fits_signed(input logic [31:0] v, input int unsigned bits);
    logic [31:0] hi;
    hi = 32'($signed(v) >>> (bits - 1));
    return (hi == '0) || (hi == '1);
  endfunction

endpackage

// File: rtl/rv_enc_fifo.sv
// Encoded-word FIFO: DEPTH entries, head shown combinationally, zero when empty.
module rv_enc_fifo
  import rv_enc_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign pop_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop && !empty) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full && !flush) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/rv_instr_encoder.sv
// RV32I field-bundle to instruction-word encoder with address-tagged output FIFO.
// Build option: define ENC_RANGE_CHECK_EN to reject out-of-range immediates.
module rv_instr_encoder
  import rv_enc_pkg::*;
#(
  parameter int unsigned DEPTH     = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_op,
  input  logic [2:0]  in_funct3,
  input  logic        in_funct7,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_addr,
  output logic        err_pulse,
  output logic [7:0]  err_count
);

  logic [31:0] word;
  logic [31:0] next_addr;
  logic        op_ok;
  logic        imm_ok;
  logic        is_shift;
  logic        full;
  logic        empty;
  logic        accept;
  logic        push;
  logic        reject;
  logic [63:0] head;

  assign is_shift = (in_funct3 == 3'b001) || (in_funct3 == 3'b101);

  always_comb begin
    word  = '0;
    op_ok = 1'b1;
    case (in_op)
      OP_LUI:    word = fmt_u(in_imm[31:12], in_rd, OPC_LUI);
      OP_AUIPC:  word = fmt_u(in_imm[31:12], in_rd, OPC_AUIPC);
      OP_JAL:    word = fmt_j(in_imm[20:1], in_rd, OPC_JAL);
      OP_JALR:   word = fmt_i(in_imm[11:0], in_rs1, in_funct3, in_rd, OPC_JALR);
      OP_BRANCH: word = fmt_b(in_imm[12:1], in_rs2, in_rs1, in_funct3, OPC_BRANCH);
      OP_LOAD:   word = fmt_i(in_imm[11:0], in_rs1, in_funct3, in_rd, OPC_LOAD);
      OP_STORE:  word = fmt_s(in_imm[11:0], in_rs2, in_rs1, in_funct3, OPC_STORE);
      OP_OPIMM:
        if (is_shift) word = fmt_r({1'b0, in_funct7, 5'b0}, in_imm[4:0], in_rs1, in_funct3, in_rd, OPC_OPIMM);
        else          word = fmt_i(in_imm[11:0], in_rs1, in_funct3, in_rd, OPC_OPIMM);
      OP_OP:     word = fmt_r({1'b0, in_funct7, 5'b0}, in_rs2, in_rs1, in_funct3, in_rd, OPC_OP);
      OP_FENCE:  word = fmt_i(in_imm[11:0], 5'd0, 3'b000, 5'd0, OPC_FENCE);
      // imm[0] selects EBREAK (funct12 = 1) over ECALL.
      OP_SYSTEM: word = {11'd0, in_imm[0], 13'd0, OPC_SYSTEM};
      default:   op_ok = 1'b0;
    endcase
  end

`ifdef ENC_RANGE_CHECK_EN
  always_comb begin
    imm_ok = 1'b1;
    case (in_op)
      OP_LUI, OP_AUIPC: imm_ok = (in_imm[11:0] == 12'd0);
      OP_JAL:           imm_ok = fits_signed(in_imm, 21) && !in_imm[0];
      OP_BRANCH:        imm_ok = fits_signed(in_imm, 13) && !in_imm[0];
      OP_JALR, OP_LOAD, OP_STORE, OP_FENCE: imm_ok = fits_signed(in_imm, 12);
      OP_OPIMM:         imm_ok = is_shift ? (in_imm[31:5] == 27'd0) : fits_signed(in_imm, 12);
      default:          imm_ok = 1'b1;
    endcase
  end
`else
  assign imm_ok = 1'b1;
`endif

  assign in_ready = !full;
  assign accept   = in_valid && in_ready;
  assign push     = accept && op_ok && imm_ok && !flush;
  assign reject   = accept && !(op_ok && imm_ok);

  rv_enc_fifo #(.DEPTH(DEPTH), .WIDTH(64)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .push      (push),
    .push_data ({word, next_addr}),
    .pop       (out_ready),
    .pop_data  (head),
    .full      (full),
    .empty     (empty)
  );

  assign out_valid = !empty;
  assign out_instr = head[63:32];
  assign out_addr  = head[31:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      next_addr <= BASE_ADDR;
      err_pulse <= 1'b0;
      err_count <= '0;
    end else begin
      err_pulse <= reject;
      if (reject && (err_count != 8'hFF)) err_count <= err_count + 8'd1;
      if (flush)     next_addr <= BASE_ADDR;
      else if (push) next_addr <= next_addr + 32'd4;
    end
  end

endmodule

// File: tb/tb_rv_instr_encoder.sv
// Self-checking bench for rv_instr_encoder: directed vectors plus randomized scoreboard run.
module tb_rv_instr_encoder;
  import rv_enc_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_op = '0;
  logic [2:0]  in_funct3 = '0;
  logic        in_funct7 = 1'b0;
  logic [4:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [31:0] in_imm = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr, out_addr;
  logic        err_pulse;
  logic [7:0]  err_count;

  int checks = 0;
  int fails  = 0;
  int exp_err_count = 0;

  rv_instr_encoder #(.DEPTH(DEPTH), .BASE_ADDR(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_funct3(in_funct3), .in_funct7(in_funct7), .in_rd(in_rd),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .out_valid(out_valid),
    .out_ready(out_ready), .out_instr(out_instr), .out_addr(out_addr),
    .err_pulse(err_pulse), .err_count(err_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference encoder: field values placed by arithmetic weights of the RV32I layouts.
  function automatic void ref_encode(input logic [3:0] op, input logic [2:0] f3, input logic f7,
                                     input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                                     input logic [31:0] imm, output bit ok, output logic [31:0] w);
    longint si;
    bit rng;
    logic [31:0] rdf, r1f, r2f, f3f, lo12;
    si   = longint'($signed(imm));
    rdf  = 32'(rd) * 128;
    r1f  = 32'(rs1) * 32768;
    r2f  = 32'(rs2) * 1048576;
    f3f  = 32'(f3) * 4096;
    lo12 = (imm % 4096) * 1048576;
    rng  = 1;
    ok   = 1;
    w    = '0;
    case (op)
      4'd0, 4'd1: begin
        w = (imm / 4096) * 4096 + rdf + ((op == 4'd0) ? 32'h37 : 32'h17);
        rng = (imm % 4096) == 0;
      end
      4'd2: begin
        w = ((imm / 1048576) % 2) * 32'h8000_0000 + ((imm / 2) % 1024) * 2097152
          + ((imm / 2048) % 2) * 1048576 + ((imm / 4096) % 256) * 4096 + rdf + 32'h6F;
        rng = (si >= -(64'sd1 <<< 20)) && (si < (64'sd1 <<< 20)) && (imm % 2 == 0);
      end
      4'd3, 4'd5: begin
        w = lo12 + r1f + f3f + rdf + ((op == 4'd3) ? 32'h67 : 32'h03);
        rng = (si >= -2048) && (si < 2048);
      end
      4'd4: begin
        w = ((imm / 4096) % 2) * 32'h8000_0000 + ((imm / 32) % 64) * 33554432 + r2f + r1f + f3f
          + ((imm / 2) % 16) * 256 + ((imm / 2048) % 2) * 128 + 32'h63;
        rng = (si >= -4096) && (si < 4096) && (imm % 2 == 0);
      end
      4'd6: begin
        w = ((imm / 32) % 128) * 33554432 + r2f + r1f + f3f + (imm % 32) * 128 + 32'h23;
        rng = (si >= -2048) && (si < 2048);
      end
      4'd7: begin
        if (f3 == 3'd1 || f3 == 3'd5) begin
          w = 32'(f7) * 32'h4000_0000 + (imm % 32) * 1048576 + r1f + f3f + rdf + 32'h13;
          rng = (si >= 0) && (si <= 31);
        end else begin
          w = lo12 + r1f + f3f + rdf + 32'h13;
          rng = (si >= -2048) && (si < 2048);
        end
      end
      4'd8: w = 32'(f7) * 32'h4000_0000 + r2f + r1f + f3f + rdf + 32'h33;
      4'd9: begin
        w = lo12 + 32'h0F;
        rng = (si >= -2048) && (si < 2048);
      end
      4'd10: w = (imm % 2 == 1) ? 32'h0010_0073 : 32'h0000_0073;
      default: ok = 0;
    endcase
`ifdef ENC_RANGE_CHECK_EN
    if (!rng) ok = 0;
`endif
  endfunction

  task automatic set_fields(input logic [3:0] op, input logic [2:0] f3, input logic f7,
                            input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                            input logic [31:0] imm);
    in_op = op; in_funct3 = f3; in_funct7 = f7; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
  endtask

  // Entered and left at a falling edge; the bundle is accepted on the rising edge in between.
  task automatic push_one(input logic [3:0] op, input logic [2:0] f3, input logic f7,
                          input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [31:0] imm);
    int n = 0;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    checks++;
    if (n >= 50) begin fails++; $display("FAIL push_wait: in_ready stayed %b, want 1", in_ready); end
    set_fields(op, f3, f7, rd, rs1, rs2, imm);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic pop_one();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic do_flush();
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
    checks++; if (out_instr !== 32'h0) begin fails++; $display("FAIL rst_out_instr got %h want 0", out_instr); end
    checks++; if (out_addr !== 32'h0) begin fails++; $display("FAIL rst_out_addr got %h want 0", out_addr); end
    checks++; if (err_pulse !== 1'b0) begin fails++; $display("FAIL rst_err_pulse got %b want 0", err_pulse); end
    checks++; if (err_count !== 8'h0) begin fails++; $display("FAIL rst_err_count got %0d want 0", err_count); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rst_in_ready got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_idle_valid got %b want 0", out_valid); end
  endtask

  typedef struct {
    logic [3:0] op; logic [2:0] f3; logic f7; logic [4:0] rd, rs1, rs2; logic [31:0] imm; logic [31:0] w;
  } vec_t;

  task automatic test_directed();
    vec_t v [8];
    bit ok;
    logic [31:0] mw;
    v[0] = '{4'd7,  3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5,         32'h0050_0093};
    v[1] = '{4'd0,  3'd0, 1'b0, 5'd2, 5'd0, 5'd0, 32'h1234_5000, 32'h1234_5137};
    v[2] = '{4'd2,  3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd8,         32'h0080_00EF};
    v[3] = '{4'd4,  3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC, 32'hFE20_8EE3};
    v[4] = '{4'd6,  3'd2, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8,         32'h0020_A423};
    v[5] = '{4'd10, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd1,         32'h0010_0073};
    v[6] = '{4'd8,  3'd0, 1'b1, 5'd3, 5'd1, 5'd2, 32'd0,         32'h4020_81B3};
    v[7] = '{4'd7,  3'd5, 1'b1, 5'd1, 5'd1, 5'd0, 32'd3,         32'h4030_D093};
    do_flush();
    for (int i = 0; i < 8; i++) begin
      push_one(v[i].op, v[i].f3, v[i].f7, v[i].rd, v[i].rs1, v[i].rs2, v[i].imm);
      ref_encode(v[i].op, v[i].f3, v[i].f7, v[i].rd, v[i].rs1, v[i].rs2, v[i].imm, ok, mw);
      checks++; if (out_valid !== 1'b1) begin fails++; $display("FAIL dir_valid[%0d] got %b want 1", i, out_valid); end
      checks++; if (out_instr !== v[i].w) begin fails++; $display("FAIL dir_instr[%0d] got %h want %h", i, out_instr, v[i].w); end
      checks++; if (out_instr !== mw) begin fails++; $display("FAIL dir_model[%0d] got %h want %h", i, out_instr, mw); end
      checks++; if (out_addr !== 32'(4 * i)) begin fails++; $display("FAIL dir_addr[%0d] got %h want %h", i, out_addr, 4 * i); end
      pop_one();
      checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL dir_drained[%0d] got %b want 0", i, out_valid); end
    end
  endtask

  task automatic test_errors();
    do_flush();
    push_one(4'hF, 3'd0, 1'b0, 5'd1, 5'd1, 5'd1, 32'd0);
    exp_err_count++;
    checks++; if (err_pulse !== 1'b1) begin fails++; $display("FAIL badop_pulse got %b want 1", err_pulse); end
    checks++; if (err_count !== 8'(exp_err_count)) begin fails++; $display("FAIL badop_count got %0d want %0d", err_count, exp_err_count); end
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL badop_enq got %b want 0", out_valid); end
    @(negedge clk);
    checks++; if (err_pulse !== 1'b0) begin fails++; $display("FAIL badop_pulse_len got %b want 0", err_pulse); end
    // 4096 is out of 12-bit range and truncates to imm 0.
    push_one(4'd7, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd4096);
`ifdef ENC_RANGE_CHECK_EN
    exp_err_count++;
    checks++; if (err_pulse !== 1'b1) begin fails++; $display("FAIL range_pulse got %b want 1", err_pulse); end
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL range_enq got %b want 0", out_valid); end
`else
    checks++; if (out_instr !== 32'h0000_0013) begin fails++; $display("FAIL trunc_instr got %h want 00000013", out_instr); end
    checks++; if (err_pulse !== 1'b0) begin fails++; $display("FAIL trunc_pulse got %b want 0", err_pulse); end
    pop_one();
`endif
    checks++; if (err_count !== 8'(exp_err_count)) begin fails++; $display("FAIL range_count got %0d want %0d", err_count, exp_err_count); end
    push_one(4'd7, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5);
`ifdef ENC_RANGE_CHECK_EN
    checks++; if (out_addr !== 32'd0) begin fails++; $display("FAIL after_err_addr got %h want 0", out_addr); end
`else
    checks++; if (out_addr !== 32'd4) begin fails++; $display("FAIL after_err_addr got %h want 4", out_addr); end
`endif
    checks++; if (out_instr !== 32'h0050_0093) begin fails++; $display("FAIL after_err_instr got %h want 00500093", out_instr); end
    pop_one();
  endtask

  task automatic test_backpressure();
    bit ok;
    logic [31:0] mw;
    int got = 0;
    int n = 0;
    do_flush();
    for (int k = 0; k < 4; k++) push_one(4'd7, 3'd0, 1'b0, 5'(k + 1), 5'd0, 5'd0, 32'(k + 1));
    checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_full_ready got %b want 0", in_ready); end
    set_fields(4'd7, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'd5);
    in_valid = 1'b1;
    out_ready = 1'b1;
    checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_pop_ready got %b want 0", in_ready); end
    while (got < 5 && n < 30) begin
      if (out_valid && out_ready) begin
        ref_encode(4'd7, 3'd0, 1'b0, 5'(got + 1), 5'd0, 5'd0, 32'(got + 1), ok, mw);
        checks++; if (out_instr !== mw) begin fails++; $display("FAIL bp_instr[%0d] got %h want %h", got, out_instr, mw); end
        checks++; if (out_addr !== 32'(4 * got)) begin fails++; $display("FAIL bp_addr[%0d] got %h want %h", got, out_addr, 4 * got); end
        got++;
      end
      @(negedge clk);
      if (in_valid && n > 0) in_valid = 1'b0;
      n++;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    checks++; if (got != 5) begin fails++; $display("FAIL bp_drain_count got %0d want 5", got); end
  endtask

  task automatic test_flush();
    do_flush();
    for (int k = 0; k < 3; k++) push_one(4'd8, 3'd0, 1'b0, 5'(k), 5'd1, 5'd2, 32'd0);
    checks++; if (out_valid !== 1'b1) begin fails++; $display("FAIL fl_pre_valid got %b want 1", out_valid); end
    set_fields(4'd7, 3'd0, 1'b0, 5'd9, 5'd0, 5'd0, 32'd9);
    in_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL fl_valid got %b want 0", out_valid); end
    checks++; if (out_instr !== 32'h0) begin fails++; $display("FAIL fl_instr got %h want 0", out_instr); end
    checks++; if (out_addr !== 32'h0) begin fails++; $display("FAIL fl_addr got %h want 0", out_addr); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL fl_push_lost got %b want 0", out_valid); end
    push_one(4'd0, 3'd0, 1'b0, 5'd2, 5'd0, 5'd0, 32'h1234_5000);
    checks++; if (out_addr !== 32'h0) begin fails++; $display("FAIL fl_next_addr got %h want 0", out_addr); end
    checks++; if (out_instr !== 32'h1234_5137) begin fails++; $display("FAIL fl_next_instr got %h want 12345137", out_instr); end
    checks++; if (err_count !== 8'(exp_err_count)) begin fails++; $display("FAIL fl_err_kept got %0d want %0d", err_count, exp_err_count); end
    pop_one();
  endtask

  task automatic test_random();
    logic [63:0] q [$];
    logic [31:0] addr = 0;
    bit exp_pulse = 0;
    bit ok;
    logic [31:0] mw;
    logic [31:0] imm;
    int pre;
    do_flush();
    for (int i = 0; i < 400; i++) begin
      checks++; if (out_valid !== (q.size() != 0)) begin fails++; $display("FAIL rnd_valid[%0d] got %b want %b", i, out_valid, q.size() != 0); end
      checks++; if (in_ready !== (q.size() < DEPTH)) begin fails++; $display("FAIL rnd_ready[%0d] got %b want %b", i, in_ready, q.size() < DEPTH); end
      if (q.size() != 0) begin
        checks++; if ({out_instr, out_addr} !== q[0]) begin fails++; $display("FAIL rnd_head[%0d] got %h/%h want %h/%h", i, out_instr, out_addr, q[0][63:32], q[0][31:0]); end
      end else begin
        checks++; if ({out_instr, out_addr} !== 64'h0) begin fails++; $display("FAIL rnd_empty_head[%0d] got %h/%h want 0/0", i, out_instr, out_addr); end
      end
      checks++; if (err_pulse !== exp_pulse) begin fails++; $display("FAIL rnd_pulse[%0d] got %b want %b", i, err_pulse, exp_pulse); end
      checks++; if (err_count !== 8'(exp_err_count)) begin fails++; $display("FAIL rnd_count[%0d] got %0d want %0d", i, err_count, exp_err_count); end
      case ($urandom_range(0, 3))
        0: imm = 32'($urandom_range(0, 4095)) - 32'd2048;
        1: imm = 32'($urandom_range(0, 63)) * 2;
        2: imm = $urandom & 32'hFFFF_F000;
        default: imm = $urandom;
      endcase
      set_fields(($urandom_range(0, 7) == 0) ? 4'($urandom_range(11, 15)) : 4'($urandom_range(0, 10)),
                 3'($urandom), 1'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), imm);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) == 0);
      pre = q.size();
      exp_pulse = 0;
      if (out_ready && pre != 0) void'(q.pop_front());
      if (in_valid && pre < DEPTH) begin
        ref_encode(in_op, in_funct3, in_funct7, in_rd, in_rs1, in_rs2, in_imm, ok, mw);
        if (ok) begin
          q.push_back({mw, addr});
          addr = addr + 32'd4;
        end else begin
          exp_pulse = 1;
          if (exp_err_count < 255) exp_err_count++;
        end
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    push_one(4'd7, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd1);
    push_one(4'hE, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd1);
    if (exp_err_count < 255) exp_err_count++;
    checks++; if (err_count !== 8'(exp_err_count)) begin fails++; $display("FAIL ar_pre_count got %0d want %0d", err_count, exp_err_count); end
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL ar_valid got %b want 0", out_valid); end
    checks++; if (out_instr !== 32'h0) begin fails++; $display("FAIL ar_instr got %h want 0", out_instr); end
    checks++; if (out_addr !== 32'h0) begin fails++; $display("FAIL ar_addr got %h want 0", out_addr); end
    checks++; if (err_count !== 8'h0) begin fails++; $display("FAIL ar_count got %0d want 0", err_count); end
    checks++; if (err_pulse !== 1'b0) begin fails++; $display("FAIL ar_pulse got %b want 0", err_pulse); end
    exp_err_count = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    push_one(4'd2, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd8);
    checks++; if (out_addr !== 32'h0) begin fails++; $display("FAIL ar_next_addr got %h want 0", out_addr); end
    checks++; if (out_instr !== 32'h0080_00EF) begin fails++; $display("FAIL ar_next_instr got %h want 008000ef", out_instr); end
    pop_one();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_errors();
    test_backpressure();
    test_flush();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
